multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Sequencing controller for the multicycle CPU's HI/LO path. It runs signed MULT and DIV as 32-iteration shift/add and shift/subtract sequences, owns the HI and LO registers, and signals a stall to the main control unit while busy. It also drives the 4-bit write-source select for the register-file write mux: 0000 ALU, 0001 HI, 0010 LO, 0011 Shift. Placement: between the main control FSM, the A/B operand registers and the write-source mux.

## Interface
Parameters:
- `ITER`, 32: iteration count; fixed for the 32-bit datapath.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe; sampled on the rising edge of `clk`.
- `op` in 2: 00 MULT, 01 DIV, 10 MFHI, 11 MFLO.
- `a_in` in 32: rs operand, two's complement.
- `b_in` in 32: rt operand, two's complement.
- `busy` out 1: high while a MULT/DIV is in progress; the main FSM stalls on it.
- `done` out 1: one-cycle pulse when an operation completes.
- `div0` out 1: one-cycle pulse when a DIV has a zero divisor.
- `hi_out` out 32: HI register.
- `lo_out` out 32: LO register.
- `wr_sel` out 4: write-source select for the register-file write mux.

## Operation
States: IDLE, CALC, FIXUP, DONE.

IDLE / DONE:
- `start` is accepted in either state.
- MULT or DIV with nonzero `b_in`: latch operand magnitudes and the result sign flags, load counter = 31, go to CALC.
- DIV with `b_in` = 0: go to DONE; `done` and `div0` pulse; HI and LO unchanged.
- MFHI / MFLO: go to DONE; `done` pulses and `wr_sel` = 0001 / 0010 for that one cycle.
- No `start`: DONE returns to IDLE.

CALC:
- MULT: 64-bit unsigned shift-add on the magnitudes, one bit per cycle.
- DIV: restoring division with a 33-bit partial remainder.
- Counter decrements each cycle; at 0, go to FIXUP.

FIXUP:
- MULT: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
- DIV: quotient is negated if the signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Go to DONE.

Width rules:
- Magnitudes are held as 33-bit unsigned values, so abs(0x80000000) is exact.
- Results are truncated to 32/64 bits; no overflow flag.
- 0x80000000 / -1 gives LO = 0x80000000, HI = 0.

Boundary behaviour:
- `start` while `busy`: ignored, no side effects.
- `op` and operands only matter on the accepting edge.
- `wr_sel` is 0000 in every cycle except an MF* DONE cycle.

## Timing
- Reset values: state IDLE; `busy`, `done`, `div0` = 0; `hi_out` = `lo_out` = 0; `wr_sel` = 0000; counter = 0. Reset takes effect immediately, including mid-CALC, and discards any partial result.
- MULT/DIV, with the accepting edge as E0:
  - `busy` is high from after E0 through the FIXUP cycle.
  - CALC occupies E1..E32, FIXUP E33.
  - `hi_out`/`lo_out` update at E33.
  - `done` is high in the cycle after E33.
  - Total latency: 34 cycles from the `start` edge to `done`.
- Divide-by-zero and MF*: `done` (and `div0` or `wr_sel`) are high in the cycle after E0. Latency 1; `busy` never rises.
- Back-to-back: a `start` during the DONE cycle is accepted. No idle bubble is required.
- All outputs are registered.

## Structure
- Package `multdiv_pkg`:
  - op codes OP_MULT, OP_DIV, OP_MFHI, OP_MFLO;
  - state enum;
  - WRSEL_ALU = 0000, WRSEL_HI = 0001, WRSEL_LO = 0010, WRSEL_SHIFT = 0011 (shared with the write-source mux);
  - ITER.
- One sub-module, `multdiv_core`: the 64-bit accumulator/remainder shift registers and the sign fix-up, controlled by `load`, `step`, `fix` and `is_div`.
- The FSM, counter and HI/LO registers stay in `multdiv_ctrl`.

## Test plan
- MULT a=7, b=-3 (0xFFFFFFFD) -> `busy` high for cycles 1..33; `done` at cycle 34; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF at cycle 34. DIV 5 / 0 -> `done` and `div0` pulse at cycle 1; HI and LO keep their prior values.
- After the MULT above: MFHI -> `wr_sel` = 0001 with `done` at cycle 1, then 0000. MFLO -> `wr_sel` = 0010 for one cycle.
- `start` (DIV 9 / 4) asserted at cycle 5 of a running MULT -> ignored; the MULT result is unaffected. Then issue DIV 9 / 4 during the MULT's DONE cycle -> accepted; LO = 2, HI = 1 after 34 cycles.
- `reset` asserted asynchronously at cycle 10 of a MULT -> `busy` = 0, state IDLE, HI = LO = 0 immediately, no `done`. The next MULT 2 × 3 -> LO = 6.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide path: op codes, FSM states,
// write-source select encodings and the magnitude helper.
package multdiv_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MFHI = 2'b10,
    OP_MFLO = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [3:0] WRSEL_ALU   = 4'b0000;
  localparam logic [3:0] WRSEL_HI    = 4'b0001;
  localparam logic [3:0] WRSEL_LO    = 4'b0010;
  localparam logic [3:0] WRSEL_SHIFT = 4'b0011;

  // 33-bit result so that abs(0x80000000) = 0x0_8000_0000 exactly.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    return v[31] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

// File: rtl/multdiv_core.sv
// Shift/add multiply and restoring divide datapath with sign fix-up.
// acc holds {hi, lo}: product for MULT, {remainder, quotient} for DIV.
module multdiv_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        fix,
  input  logic        is_div,
  input  logic [31:0] acc_ld,
  input  logic [32:0] opnd_ld,
  input  logic        neg_q,
  input  logic        neg_r,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  import multdiv_pkg::*;

  logic [63:0] acc;
  logic [32:0] opnd;
  logic        nq;
  logic        nr;

  logic [32:0] msum;
  logic [32:0] rshift;
  logic        taken;
  logic [31:0] rdiff;
  logic [63:0] pneg;

  always_comb begin
    msum   = {1'b0, acc[63:32]} + (acc[0] ? opnd : 33'd0);
    rshift = {acc[63:32], acc[31]};
    taken  = (rshift >= opnd);
    // When the subtraction is taken the true difference is below the divisor,
    // so a 32-bit modular subtract is exact.
    rdiff  = rshift[31:0] - opnd[31:0];
    pneg   = ~acc + 64'd1;
    if (is_div) begin
      res_lo = nq ? (~acc[31:0] + 32'd1) : acc[31:0];
      res_hi = nr ? (~acc[63:32] + 32'd1) : acc[63:32];
    end else begin
      res_lo = nq ? pneg[31:0]  : acc[31:0];
      res_hi = nq ? pneg[63:32] : acc[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
      nq   <= 1'b0;
      nr   <= 1'b0;
    end else if (load) begin
      acc  <= {32'd0, acc_ld};
      opnd <= opnd_ld;
      nq   <= neg_q;
      nr   <= neg_r;
    end else if (step) begin
      if (is_div)
        acc <= taken ? {rdiff, acc[30:0], 1'b1} : {rshift[31:0], acc[30:0], 1'b0};
      else
        acc <= {msum, acc[31:1]};
    end else if (fix) begin
      acc <= {res_hi, res_lo};
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// HI/LO sequencing controller: accepts MULT/DIV/MFHI/MFLO requests, stalls the
// main FSM while the core iterates, and owns the HI/LO registers.
module multdiv_ctrl #(
  parameter int unsigned ITER = multdiv_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [3:0]  wr_sel
);
  import multdiv_pkg::*;

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div_q;

  op_t         opc;
  logic        accept;
  logic        take_arith;
  logic        div_sel;
  logic [32:0] a_mag;
  logic [32:0] b_mag;
  logic [31:0] acc_ld;
  logic [32:0] opnd_ld;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    opc        = op_t'(op);
    accept     = start && (state == S_IDLE || state == S_DONE);
    take_arith = accept && (opc == OP_MULT || (opc == OP_DIV && b_in != '0));
    // Mode follows the incoming op on the loading edge, the latched op afterwards.
    div_sel    = take_arith ? (opc == OP_DIV) : is_div_q;
    a_mag      = mag33(a_in);
    b_mag      = mag33(b_in);
    acc_ld     = div_sel ? a_mag[31:0] : b_mag[31:0];
    opnd_ld    = div_sel ? b_mag : a_mag;
  end

  multdiv_core u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (take_arith),
    .step    (state == S_CALC),
    .fix     (state == S_FIXUP),
    .is_div  (div_sel),
    .acc_ld  (acc_ld),
    .opnd_ld (opnd_ld),
    .neg_q   (a_in[31] ^ b_in[31]),
    .neg_r   (a_in[31]),
    .res_hi  (res_hi),
    .res_lo  (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      wr_sel   <= WRSEL_ALU;
    end else begin
      done   <= 1'b0;
      div0   <= 1'b0;
      wr_sel <= WRSEL_ALU;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            case (opc)
              OP_MULT, OP_DIV: begin
                if (take_arith) begin
                  state    <= S_CALC;
                  cnt      <= CNT_LOAD;
                  busy     <= 1'b1;
                  is_div_q <= (opc == OP_DIV);
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  div0  <= 1'b1;
                end
              end
              OP_MFHI: begin
                state  <= S_DONE;
                done   <= 1'b1;
                wr_sel <= WRSEL_HI;
              end
              default: begin
                state  <= S_DONE;
                done   <= 1'b1;
                wr_sel <= WRSEL_LO;
              end
            endcase
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (cnt == '0)
            state <= S_FIXUP;
          else
            cnt <= cnt - 1'b1;
        end
        S_FIXUP: begin
          hi_out <= res_hi;
          lo_out <= res_lo;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl; cycle k is the interval after the k-th edge
// following the accepting edge, sampled on the falling edge.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [3:0]  wr_sel;

  int checks = 0;
  int failures = 0;

  multdiv_ctrl #(.ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .div0   (div0),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .wr_sel (wr_sel)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
  endtask

  // Junk operands after the accepting edge: they must not affect anything.
  task automatic drop_start();
    start = 1'b0;
    op    = 2'b11;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h0000_0000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL reset_div0 got=%b exp=0", div0); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo_out); end
    checks++; if (wr_sel !== 4'b0000) begin failures++; $display("FAIL reset_wrsel got=%b exp=0000", wr_sel); end
    reset = 1'b0;
  endtask

  task automatic test_mult_neg();
    @(negedge clk);
    drive(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
      checks++;
      if (busy !== (k <= 33)) begin failures++; $display("FAIL mult_busy cycle=%0d got=%b exp=%b", k, busy, (k <= 33)); end
      checks++;
      if (done !== (k == 34)) begin failures++; $display("FAIL mult_done cycle=%0d got=%b exp=%b", k, done, (k == 34)); end
      checks++;
      if (wr_sel !== WRSEL_ALU) begin failures++; $display("FAIL mult_wrsel cycle=%0d got=%b exp=0000", k, wr_sel); end
    end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mf();
    @(negedge clk);
    drive(OP_MFHI, 32'h1111_1111, 32'h0);
    @(negedge clk);
    drop_start();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mfhi_done got=%b exp=1", done); end
    checks++; if (wr_sel !== 4'b0001) begin failures++; $display("FAIL mfhi_wrsel got=%b exp=0001", wr_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mfhi_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (wr_sel !== 4'b0000) begin failures++; $display("FAIL mfhi_wrsel_after got=%b exp=0000", wr_sel); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mfhi_done_after got=%b exp=0", done); end
    drive(OP_MFLO, 32'h0, 32'h2222_2222);
    @(negedge clk);
    drop_start();
    checks++; if (wr_sel !== 4'b0010) begin failures++; $display("FAIL mflo_wrsel got=%b exp=0010", wr_sel); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mflo_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (wr_sel !== 4'b0000) begin failures++; $display("FAIL mflo_wrsel_after got=%b exp=0000", wr_sel); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mf_hi_kept got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mf_lo_kept got=%h exp=ffffffeb", lo_out); end
  endtask

  task automatic test_extremes();
    @(negedge clk);
    drive(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL minmul_done got=%b exp=1", done); end
    checks++; if (hi_out !== 32'h4000_0000) begin failures++; $display("FAIL minmul_hi got=%h exp=40000000", hi_out); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL minmul_lo got=%h exp=00000000", lo_out); end
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mindiv_done got=%b exp=1", done); end
    checks++; if (lo_out !== 32'h8000_0000) begin failures++; $display("FAIL mindiv_lo got=%h exp=80000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL mindiv_hi got=%h exp=00000000", hi_out); end
  endtask

  task automatic test_div_neg();
    @(negedge clk);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
      if (k == 33) begin
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL divneg_early_done got=%b exp=0", done); end
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL divneg_done got=%b exp=1", done); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divneg_lo got=%h exp=fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divneg_hi got=%h exp=ffffffff", hi_out); end
  endtask

  task automatic test_div0();
    @(negedge clk);
    drive(OP_DIV, 32'd5, 32'd0);
    @(negedge clk);
    drop_start();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL div0_done got=%b exp=1", done); end
    checks++; if (div0 !== 1'b1) begin failures++; $display("FAIL div0_flag got=%b exp=1", div0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div0_busy got=%b exp=0", busy); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_hi_kept got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div0_lo_kept got=%h exp=fffffffd", lo_out); end
    @(negedge clk);
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL div0_pulse got=%b exp=0", div0); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL div0_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(OP_MULT, 32'd1000, 32'd3);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1 || k == 6) drop_start();
      if (k == 5) drive(OP_DIV, 32'd9, 32'd4);
      checks++;
      if (busy !== (k <= 33)) begin failures++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", k, busy, (k <= 33)); end
      checks++;
      if (done !== (k == 34)) begin failures++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", k, done, (k == 34)); end
    end
    checks++; if (lo_out !== 32'd3000) begin failures++; $display("FAIL b2b_mult_lo got=%h exp=00000bb8", lo_out); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL b2b_mult_hi got=%h exp=00000000", hi_out); end
    drive(OP_DIV, 32'd9, 32'd4);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) begin
        drop_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_accept_done got=%b exp=0", done); end
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_div_done got=%b exp=1", done); end
    checks++; if (lo_out !== 32'd2) begin failures++; $display("FAIL b2b_div_lo got=%h exp=00000002", lo_out); end
    checks++; if (hi_out !== 32'd1) begin failures++; $display("FAIL b2b_div_hi got=%h exp=00000001", hi_out); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(OP_MULT, 32'h0001_2345, 32'h0000_0100);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=00000000", hi_out); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=00000000", lo_out); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL rstmid_quiet cycle=%0d got done=%b busy=%b exp done=0 busy=0", k, done, busy);
      end
    end
    drive(OP_MULT, 32'd2, 32'd3);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) drop_start();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rstmid_next_done got=%b exp=1", done); end
    checks++; if (lo_out !== 32'd6) begin failures++; $display("FAIL rstmid_next_lo got=%h exp=00000006", lo_out); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL rstmid_next_hi got=%h exp=00000000", hi_out); end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult_neg();
    test_mf();
    test_extremes();
    test_div_neg();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
